// File: rtl/nw_scan_if.sv
// Handshake and cell-coordinate bundle between the fill controller (master)
// and the score-matrix scan counter (slave).
interface nw_scan_if #(
   parameter int ROWS = 128,
   parameter int COLS = 128
);
   localparam int IW = $clog2(ROWS) + 1;
   localparam int JW = $clog2(COLS) + 1;
   localparam int AW = $clog2(ROWS * COLS);

   logic          start;
   logic          mode;
   logic          step;
   logic          clear;
   logic          valid;
   logic [IW-1:0] i;
   logic [JW-1:0] j;
   logic [AW-1:0] addr;
   logic          last;
   logic          diag_first;
   logic          done;
   logic          busy;

   modport master (
      output start, mode, step, clear,
      input  valid, i, j, addr, last, diag_first, done, busy
   );

   modport slave (
      input  start, mode, step, clear,
      output valid, i, j, addr, last, diag_first, done, busy
   );
endinterface

// File: rtl/nw_scan_counter.sv
// Score-matrix traversal counter: walks a ROWS x COLS matrix in row-major or
// anti-diagonal order, presenting (i, j) and the linear address per accepted step.
module nw_scan_counter #(
   parameter int ROWS  = 128,
   parameter int COLS  = 128,
   parameter int FIRST = 0
) (
   input  logic     clk,
   input  logic     rst_n,
   nw_scan_if.slave bus
);
   localparam int IW = $clog2(ROWS) + 1;
   localparam int JW = $clog2(COLS) + 1;
   localparam int AW = $clog2(ROWS * COLS);
   // Diagonal index reaches ROWS+COLS-2, so size it from the wider axis plus one.
   localparam int DW = ((IW > JW) ? IW : JW) + 1;

   localparam logic [IW-1:0] I_FIRST   = IW'(FIRST);
   localparam logic [IW-1:0] I_MAX     = IW'(ROWS - 1);
   localparam logic [JW-1:0] J_FIRST   = JW'(FIRST);
   localparam logic [JW-1:0] J_MAX     = JW'(COLS - 1);
   localparam logic [AW-1:0] A_FIRST   = AW'(FIRST * COLS + FIRST);
   localparam logic [AW-1:0] A_ROWWRAP = AW'(FIRST + 1);
   localparam logic [AW-1:0] A_DIAG    = AW'(COLS - 1);
   localparam logic [AW-1:0] A_COLS    = AW'(COLS);
   localparam logic [DW-1:0] D_FIRST   = DW'(FIRST);
   localparam logic [DW-1:0] D_CM1     = DW'(COLS - 1);
   localparam logic [DW-1:0] D_KNEE    = DW'(COLS - 1 + FIRST);
   localparam logic [DW-1:0] D_RMAX    = DW'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic          mode_q, mode_d;
   logic [IW-1:0] i_q, i_d;
   logic [JW-1:0] j_q, j_d;
   logic [AW-1:0] addr_q, addr_d;

   logic          valid_w;
   logic          last_w;
   logic [DW-1:0] d_cur, d_nxt, d_rel;
   logic [DW-1:0] lo_cur, lo_nxt, hi_cur;
   logic [AW-1:0] addr_jump;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mode_q  <= 1'b0;
         i_q     <= I_FIRST;
         j_q     <= J_FIRST;
         addr_q  <= A_FIRST;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         i_q     <= i_d;
         j_q     <= j_d;
         addr_q  <= addr_d;
      end
   end

   // Anti-diagonal bounds for the current diagonal and the one after it.
   assign d_cur     = DW'(i_q) + DW'(j_q);
   assign d_nxt     = d_cur + DW'(1);
   assign d_rel     = d_cur - D_FIRST;
   assign lo_cur    = (d_cur >= D_KNEE) ? (d_cur - D_CM1) : D_FIRST;
   assign lo_nxt    = (d_nxt >= D_KNEE) ? (d_nxt - D_CM1) : D_FIRST;
   assign hi_cur    = (d_rel < D_RMAX) ? d_rel : D_RMAX;
   assign addr_jump = AW'(lo_nxt) * A_COLS + AW'(d_nxt - lo_nxt);

   assign valid_w = (state_q == RUN);
   assign last_w  = valid_w && (i_q == I_MAX) && (j_q == J_MAX);

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      i_d     = i_q;
      j_d     = j_q;
      addr_d  = addr_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               mode_d  = bus.mode;
            end
         end
         RUN: begin
            if (bus.step) begin
               if (last_w) begin
                  state_d = DONE;
                  i_d     = I_FIRST;
                  j_d     = J_FIRST;
                  addr_d  = A_FIRST;
               end else if (!mode_q) begin
                  if (j_q < J_MAX) begin
                     j_d    = j_q + JW'(1);
                     addr_d = addr_q + AW'(1);
                  end else begin
                     i_d    = i_q + IW'(1);
                     j_d    = J_FIRST;
                     addr_d = addr_q + A_ROWWRAP;
                  end
               end else begin
                  if (DW'(i_q) < hi_cur) begin
                     i_d    = i_q + IW'(1);
                     j_d    = j_q - JW'(1);
                     addr_d = addr_q + A_DIAG;
                  end else begin
                     i_d    = IW'(lo_nxt);
                     j_d    = JW'(d_nxt - lo_nxt);
                     addr_d = addr_jump;
                  end
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.clear) begin
         state_d = IDLE;
         i_d     = I_FIRST;
         j_d     = J_FIRST;
         addr_d  = A_FIRST;
      end
   end

   assign bus.valid      = valid_w;
   assign bus.i          = i_q;
   assign bus.j          = j_q;
   assign bus.addr       = addr_q;
   assign bus.last       = last_w;
   assign bus.diag_first = valid_w && mode_q && (DW'(i_q) == lo_cur);
   assign bus.done       = (state_q == DONE);
   assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_nw_scan_counter.sv
// Directed bench for nw_scan_counter: row-major 4x3, anti-diagonal 3x3 with
// border skip, anti-diagonal 3x4 with stalls, clear and asynchronous reset.
module tb_nw_scan_counter;
   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   nw_scan_if #(.ROWS(4), .COLS(3)) a ();
   nw_scan_if #(.ROWS(3), .COLS(3)) b ();
   nw_scan_if #(.ROWS(3), .COLS(4)) c ();

   nw_scan_counter #(.ROWS(4), .COLS(3), .FIRST(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(a));
   nw_scan_counter #(.ROWS(3), .COLS(3), .FIRST(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(b));
   nw_scan_counter #(.ROWS(3), .COLS(4), .FIRST(0)) u_c (.clk(clk), .rst_n(rst_n), .bus(c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Full row-major pass on instance a with step held high; caller is at a negedge.
   task automatic row_pass(input string tag);
      a.start = 1'b1;
      a.mode  = 1'b0;
      a.step  = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         a.start = 1'b0;
         chk($sformatf("%s%0d_valid", tag, k), a.valid, 1);
         chk($sformatf("%s%0d_addr", tag, k), a.addr, k);
         chk($sformatf("%s%0d_i", tag, k), a.i, k / 3);
         chk($sformatf("%s%0d_j", tag, k), a.j, k % 3);
         chk($sformatf("%s%0d_last", tag, k), a.last, (k == 11));
         chk($sformatf("%s%0d_done", tag, k), a.done, 0);
      end
      @(negedge clk);
      chk({tag, "_end_valid"}, a.valid, 0);
      chk({tag, "_end_done"}, a.done, 1);
      chk({tag, "_end_busy"}, a.busy, 1);
      @(negedge clk);
      chk({tag, "_idle_done"}, a.done, 0);
      chk({tag, "_idle_busy"}, a.busy, 0);
      a.step = 1'b0;
      $display("row pass %s complete", tag);
   endtask

   int bi [4];
   int bj [4];
   int bdf[4];
   int ci [12];
   int cj [12];
   int cdf[12];
   int gap;

   initial begin
      n_vec = 0;
      n_err = 0;
      bi  = '{1, 1, 2, 2};
      bj  = '{1, 2, 1, 2};
      bdf = '{1, 1, 0, 1};
      ci  = '{0, 0, 1, 0, 1, 2, 0, 1, 2, 1, 2, 2};
      cj  = '{0, 1, 0, 2, 1, 0, 3, 2, 1, 3, 2, 3};
      cdf = '{1, 1, 0, 1, 0, 0, 1, 0, 0, 1, 0, 1};
      {a.start, a.mode, a.step, a.clear} = 4'b0;
      {b.start, b.mode, b.step, b.clear} = 4'b0;
      {c.start, c.mode, c.step, c.clear} = 4'b0;
      rst_n = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_a_valid", a.valid, 0);
      chk("rst_a_busy", a.busy, 0);
      chk("rst_a_done", a.done, 0);
      chk("rst_a_addr", a.addr, 0);
      chk("rst_b_i", b.i, 1);
      chk("rst_b_j", b.j, 1);
      chk("rst_b_addr", b.addr, 4);
      rst_n = 1'b1;
      $display("reset released");

      // step while idle must not start anything
      @(negedge clk);
      c.step = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("idle_step_valid", c.valid, 0);
         chk("idle_step_busy", c.busy, 0);
         chk("idle_step_i", c.i, 0);
         chk("idle_step_j", c.j, 0);
      end
      c.step = 1'b0;

      // anti-diagonal 3x4 with random stalls and a start issued mid-run
      c.start = 1'b1;
      c.mode  = 1'b1;
      @(negedge clk);
      c.start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         chk($sformatf("C%0d_valid", k), c.valid, 1);
         chk($sformatf("C%0d_i", k), c.i, ci[k]);
         chk($sformatf("C%0d_j", k), c.j, cj[k]);
         chk($sformatf("C%0d_addr", k), c.addr, ci[k] * 4 + cj[k]);
         chk($sformatf("C%0d_df", k), c.diag_first, cdf[k]);
         chk($sformatf("C%0d_last", k), c.last, (k == 11));
         $display("C cell %0d (%0d,%0d)", k, c.i, c.j);
         c.step = 1'b0;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            c.start = 1'b1;
            @(negedge clk);
            c.start = 1'b0;
            chk($sformatf("C%0d_hold_i", k), c.i, ci[k]);
            chk($sformatf("C%0d_hold_j", k), c.j, cj[k]);
            chk($sformatf("C%0d_hold_valid", k), c.valid, 1);
         end
         c.step = 1'b1;
         @(negedge clk);
      end
      c.step = 1'b0;
      chk("C_end_done", c.done, 1);
      chk("C_end_valid", c.valid, 0);
      @(negedge clk);
      chk("C_idle_done", c.done, 0);
      chk("C_idle_busy", c.busy, 0);

      // anti-diagonal 3x3 skipping row 0 / column 0
      b.start = 1'b1;
      b.mode  = 1'b1;
      b.step  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         b.start = 1'b0;
         chk($sformatf("B%0d_valid", k), b.valid, 1);
         chk($sformatf("B%0d_i", k), b.i, bi[k]);
         chk($sformatf("B%0d_j", k), b.j, bj[k]);
         chk($sformatf("B%0d_addr", k), b.addr, bi[k] * 3 + bj[k]);
         chk($sformatf("B%0d_df", k), b.diag_first, bdf[k]);
         chk($sformatf("B%0d_last", k), b.last, (k == 3));
         $display("B cell %0d (%0d,%0d)", k, b.i, b.j);
      end
      @(negedge clk);
      chk("B_end_done", b.done, 1);
      chk("B_end_valid", b.valid, 0);
      @(negedge clk);
      chk("B_idle_done", b.done, 0);
      chk("B_idle_busy", b.busy, 0);
      b.step = 1'b0;

      row_pass("A");

      // clear mid-pass at (1,2)
      a.start = 1'b1;
      a.mode  = 1'b0;
      @(negedge clk);
      a.start = 1'b0;
      chk("clr_first_addr", a.addr, 0);
      a.step = 1'b1;
      repeat (5) @(negedge clk);
      chk("clr_pre_i", a.i, 1);
      chk("clr_pre_j", a.j, 2);
      chk("clr_pre_addr", a.addr, 5);
      a.clear = 1'b1;
      @(negedge clk);
      a.clear = 1'b0;
      a.step  = 1'b0;
      chk("clr_valid", a.valid, 0);
      chk("clr_busy", a.busy, 0);
      chk("clr_done", a.done, 0);
      chk("clr_i", a.i, 0);
      chk("clr_j", a.j, 0);
      chk("clr_addr", a.addr, 0);
      @(negedge clk);
      chk("clr_no_done", a.done, 0);
      a.start = 1'b1;
      @(negedge clk);
      a.start = 1'b0;
      chk("clr_restart_valid", a.valid, 1);
      chk("clr_restart_i", a.i, 0);
      chk("clr_restart_j", a.j, 0);
      $display("clear sequence complete");

      // asynchronous reset between edges
      a.step = 1'b1;
      repeat (3) @(negedge clk);
      chk("ar_pre_addr", a.addr, 3);
      a.step = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", a.valid, 0);
      chk("ar_busy", a.busy, 0);
      chk("ar_addr", a.addr, 0);
      chk("ar_i", a.i, 0);
      @(negedge clk);
      rst_n = 1'b1;
      $display("async reset applied and released");
      row_pass("R");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
